// File: rtl/esc_interface.sv
`default_nettype none
// ============================================================================
//  Module   : esc_interface
//  Brief    : Single-shot PWM pulse generator for one ESC. Each wrt strobe
//             launches a pulse of MIN_CLKS + SCALE*SPEED clocks on PWM.
//  Revision : 1.0  initial release
// ============================================================================
module esc_interface #(
   parameter int unsigned MIN_CLKS = 6250,
   parameter int unsigned SCALE    = 3,
   parameter int unsigned CNT_W    = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [10:0] SPEED,
   output logic        PWM
);

   localparam logic [CNT_W-1:0] c_min_clks = CNT_W'(MIN_CLKS);
   localparam logic [CNT_W-1:0] c_scale    = CNT_W'(SCALE);

   logic [CNT_W-1:0] w_load;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pwm;

   // SPEED only feeds the load path, so an undriven SPEED while wrt=0 is harmless.
   assign w_load = c_min_clks + c_scale * CNT_W'(SPEED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_pwm <= 1'b0;
      end else if (wrt) begin
         r_cnt <= w_load;
         r_pwm <= 1'b1;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == CNT_W'(1))
            r_pwm <= 1'b0;
      end
   end

   assign PWM = r_pwm;

endmodule
`default_nettype wire

// File: tb/tb_esc_interface.sv
`default_nettype none
// ============================================================================
//  Module   : tb_esc_interface
//  Brief    : Self-checking bench for esc_interface using a time-based
//             pulse model plus directed pulse-width measurements.
//  Revision : 1.0  initial release
// ============================================================================
module tb_esc_interface;

   localparam int  MIN_CLKS = 6250;
   localparam int  SCALE    = 3;
   localparam int  CNT_W    = 14;
   localparam time PER      = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wrt = 1'b0;
   logic [10:0] SPEED = '0;
   logic        PWM;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Reference: the pulse is high while less than N periods have elapsed
   // since the most recent accepted strobe edge.
   bit  m_active = 1'b0;
   time m_t      = 0;
   int  m_n      = 0;

   esc_interface #(
      .MIN_CLKS(MIN_CLKS),
      .SCALE   (SCALE),
      .CNT_W   (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .wrt  (wrt),
      .SPEED(SPEED),
      .PWM  (PWM)
   );

   always #(PER/2) clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int width_of(input int s);
      return MIN_CLKS + SCALE * s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
      end else if (wrt) begin
         m_active = 1'b1;
         m_t      = $time;
         m_n      = width_of(int'(SPEED));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("pwm_model", PWM,
               (m_active && rst_n && (($time - m_t) < time'(m_n) * PER)) ? 1 : 0);
      end
   end

   // Caller sits on a falling edge; returns on the falling edge after the strobe.
   task automatic do_wrt(input logic [10:0] s);
      wrt   = 1'b1;
      SPEED = s;
      @(negedge clk);
      wrt   = 1'b0;
      SPEED = 11'($urandom);
   endtask

   task automatic count_high(inout int w, input int bound);
      int k = 0;
      while (PWM === 1'b1 && k < bound) begin
         w++;
         k++;
         @(negedge clk);
      end
      if (k >= bound) check("pulse_timeout", k, -1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_pwm", PWM, 0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_test(input string tag, input logic [10:0] s);
      int w = 0;
      do_wrt(s);
      count_high(w, width_of(int'(s)) + 100);
      check(tag, w, width_of(int'(s)));
      repeat (200) @(negedge clk);
      check({tag, "_low_after"}, PWM, 0);
   endtask

   initial begin
      int w;
      int gap;
      logic [10:0] s;

      repeat (3) @(negedge clk);
      check("reset_initial", PWM, 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      do_reset();
      pulse_test("width_speed10", 11'd10);
      do_reset();
      pulse_test("width_speed70", 11'd70);
      do_reset();
      pulse_test("width_speed0", 11'd0);
      pulse_test("width_speed2047", 11'd2047);

      // Retrigger 1000 clocks into a pulse: continuous high for 1000 + 6250.
      w = 0;
      do_wrt(11'd100);
      repeat (999) begin
         if (PWM === 1'b1) w++;
         @(negedge clk);
      end
      if (PWM === 1'b1) w++;
      do_wrt(11'd0);
      count_high(w, 8000);
      check("retrigger_width", w, 1000 + MIN_CLKS);

      // Async reset mid-pulse, then no pulse until the next strobe.
      do_wrt(11'd500);
      repeat (2000) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_drop", PWM, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("post_reset_idle", PWM, 0);
      pulse_test("post_reset_pulse", 11'd5);

      // Held strobe: pulse ends N cycles after the last high edge.
      wrt = 1'b1;
      SPEED = 11'd20;
      repeat (4) @(negedge clk);
      s = 11'd33;
      do_wrt(s);
      w = 0;
      count_high(w, width_of(33) + 100);
      check("held_wrt_width", w, width_of(33));

      // Randomized strobes, gaps, holds and SPEED noise checked by the model.
      for (int i = 0; i < 15; i++) begin
         s = 11'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            wrt = 1'b1;
            SPEED = 11'($urandom);
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
         do_wrt(s);
         gap = $urandom_range(20, 2000);
         for (int k = 0; k < gap; k++) begin
            if (k % 97 == 0) SPEED = 11'($urandom);
            @(negedge clk);
         end
      end
      repeat (13000) @(negedge clk);
      check("final_idle", PWM, 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
